// File: rtl/seq_pkg.sv
// Shared types and helpers for frame_sequencer.
// SEQ_PADDING_EN: when defined, row stride is padded up to a 4-byte multiple.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } seq_state_e;

    localparam int unsigned BYTES_PER_PIXEL = 3;

    // 16-bit width * 3 needs 18 bits; a 4-byte round-up still fits.
    function automatic logic [17:0] stride_bytes(input logic [15:0] width);
        logic [17:0] raw;
        raw = 18'(width) * 18'(BYTES_PER_PIXEL);
`ifdef SEQ_PADDING_EN
        return (raw + 18'd3) & ~18'd3;
`else
        return raw;
`endif
    endfunction

endpackage

// File: rtl/global.vh
// Project-wide data widths shared by the frame-processing blocks.
`ifndef GLOBAL_VH
`define GLOBAL_VH
`define PIXEL_SIZE 24
`define WORD_SIZE 32
`endif

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register tracking in-flight pixels as {valid, addr}.
module seq_delay_line #(
    parameter int unsigned Depth = 3,
    parameter int unsigned AddrW = 24
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             valid_o,
    output logic [AddrW-1:0] addr_o,
    output logic             pend_o
);

    logic [Depth-1:0] valid_q;
    logic [AddrW-1:0] addr_q [Depth];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[Depth-2:0], valid_i};
        end
    end

    // Addresses are only meaningful alongside their valid bit, so no reset.
    always_ff @(posedge clk_i) begin
        addr_q[0] <= addr_i;
        for (int i = 1; i < Depth; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign addr_o  = addr_q[Depth-1];
    // Anything still in flight apart from the slot writing back this cycle.
    assign pend_o  = |valid_q[Depth-2:0];

endmodule

// File: rtl/frame_sequencer.sv
// Streams one frame from memory through a fixed-latency pixel pipeline and writes
// results back in place. Stride padding is selected by SEQ_PADDING_EN (see seq_pkg).
`include "global.vh"

module frame_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      cfg_base_i,
    input  logic [15:0]            cfg_width_i,
    input  logic [15:0]            cfg_height_i,
    input  logic                   stall_i,
    output logic                   rd_en_o,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [`PIXEL_SIZE-1:0] rd_data_i,
    output logic                   pix_en_o,
    output logic [`PIXEL_SIZE-1:0] pix_data_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    input  logic [`PIXEL_SIZE-1:0] pix_out_i,
    output logic                   wr_en_o,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic [`PIXEL_SIZE-1:0] wr_data_o,
    output logic                   busy_o,
    output logic                   done_o
);

    seq_state_e        state_q, state_d;
    logic [15:0]       col_q, col_d, row_q, row_d;
    logic [15:0]       width_q, width_d, height_q, height_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d;
    logic              pix_en_q, pix_en_d, hsync_q, hsync_d, vsync_q, vsync_d;

    logic              dl_valid;
    logic [ADDR_W-1:0] dl_addr;
    logic              dl_pend;

    assign rd_en_o = (state_q == StRun) && !stall_i;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        width_d    = width_q;
        height_d   = height_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        pix_en_d   = rd_en_o;
        hsync_d    = rd_en_o && (col_q == 16'd0);
        vsync_d    = rd_en_o && (col_q == 16'd0) && (row_q == 16'd0);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    width_d    = cfg_width_i;
                    height_d   = cfg_height_i;
                    stride_d   = ADDR_W'(stride_bytes(cfg_width_i));
                    addr_d     = cfg_base_i;
                    row_base_d = cfg_base_i;
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = (cfg_width_i == 16'd0 || cfg_height_i == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en_o) begin
                    if (col_q == width_q - 16'd1) begin
                        col_d = '0;
                        if (row_q == height_q - 16'd1) begin
                            state_d = StDrain;
                        end else begin
                            row_d      = row_q + 16'd1;
                            row_base_d = row_base_q + stride_q;
                            addr_d     = row_base_q + stride_q;
                        end
                    end else begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + ADDR_W'(BYTES_PER_PIXEL);
                    end
                end
            end
            StDrain: begin
                if (!dl_pend) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            pix_en_q   <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            width_q    <= width_d;
            height_q   <= height_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            pix_en_q   <= pix_en_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    seq_delay_line #(
        .Depth (LATENCY + 1),
        .AddrW (ADDR_W)
    ) u_delay_line (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (rd_en_o),
        .addr_i  (addr_q),
        .valid_o (dl_valid),
        .addr_o  (dl_addr),
        .pend_o  (dl_pend)
    );

    // Data and address outputs are forced to zero whenever their strobe is low.
    assign rd_addr_o  = rd_en_o ? addr_q : '0;
    assign pix_en_o   = pix_en_q;
    assign pix_data_o = pix_en_q ? rd_data_i : '0;
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;
    assign wr_en_o    = dl_valid;
    assign wr_addr_o  = dl_valid ? dl_addr : '0;
    assign wr_data_o  = dl_valid ? pix_out_i : '0;
    assign busy_o     = (state_q == StRun) || (state_q == StDrain);
    assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised self-checking bench for frame_sequencer against a raster-order frame model.
`ifndef PIXEL_SIZE
`include "global.vh"
`endif

module tb_frame_sequencer;

    localparam int LAT = 2;
    localparam int AW  = 24;
    localparam int PW  = `PIXEL_SIZE;

    typedef struct {
        logic [AW-1:0] addr;
        logic          hs;
        logic          vs;
    } rd_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, stall;
    logic [AW-1:0] cfg_base;
    logic [15:0]   cfg_width, cfg_height;
    logic          rd_en, pix_en, hsync, vsync, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] rd_data, pix_data, pix_out, wr_data;
    logic [PW-1:0] pipe [LAT];

    frame_sequencer #(
        .LATENCY (LAT),
        .ADDR_W  (AW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .cfg_base_i   (cfg_base),
        .cfg_width_i  (cfg_width),
        .cfg_height_i (cfg_height),
        .stall_i      (stall),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .pix_en_o     (pix_en),
        .pix_data_o   (pix_data),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .pix_out_i    (pix_out),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Byte-addressed memory whose contents are a hash of the address.
    function automatic logic [PW-1:0] pix_of(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < PW / 8; k++) begin
            b = a + AW'(k);
            p[k*8 +: 8] = b[7:0] ^ b[15:8] ^ b[23:16] ^ 8'hA5;
        end
        return p;
    endfunction

    function automatic longint exp_stride(input int w);
`ifdef SEQ_PADDING_EN
        return ((longint'(w) * 3 + 3) / 4) * 4;
`else
        return longint'(w) * 3;
`endif
    endfunction

    always @(posedge clk) rd_data <= rd_en ? pix_of(rd_addr) : '0;

    // Identity pipeline of depth LAT.
    always @(posedge clk) begin
        pipe[0] <= pix_data;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign pix_out = pipe[LAT-1];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    rd_t exp_rd[$];
    wr_t exp_wr[$];
    bit            pend_v = 1'b0;
    logic [PW-1:0] pend_data;
    logic          pend_hs, pend_vs;
    int  exp_done = -1;
    bit  frame_done, frame_active, mon_en, rand_stall, stall_hold_arm;
    int  busy_from, frame_reads, frame_writes;
    int  hold_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        rd_t e;
        wr_t w;
        bit  exp_busy;
        check_eq("pix_en", 64'(pix_en), 64'(pend_v));
        if (pend_v) begin
            check_eq("pix_data", 64'(pix_data), 64'(pend_data));
            check_eq("hsync", 64'(hsync), 64'(pend_hs));
            check_eq("vsync", 64'(vsync), 64'(pend_vs));
        end else begin
            check_eq("sync_idle", 64'({hsync, vsync}), 64'd0);
        end
        pend_v = 1'b0;
        if (stall) check_eq("rd_stall", 64'(rd_en), 64'd0);
        if (rd_en) begin
            if (exp_rd.size() == 0) begin
                check_eq("rd_extra", 64'(rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_rd.pop_front();
                check_eq("rd_addr", 64'(rd_addr), 64'(e.addr));
                pend_v    = 1'b1;
                pend_data = pix_of(e.addr);
                pend_hs   = e.hs;
                pend_vs   = e.vs;
                exp_wr.push_back('{cyc + 1 + LAT, e.addr, pix_of(e.addr)});
                frame_reads++;
                if (frame_reads == 2 && stall_hold_arm) begin
                    hold_cnt       = 5;
                    stall_hold_arm = 1'b0;
                end
                if (exp_rd.size() == 0) exp_done = cyc + LAT + 2;
            end
        end
        if (wr_en) begin
            if (exp_wr.size() == 0) begin
                check_eq("wr_extra", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check_eq("wr_cyc", 64'(cyc), 64'(w.cyc));
                check_eq("wr_addr", 64'(wr_addr), 64'(w.addr));
                check_eq("wr_data", 64'(wr_data), 64'(w.data));
                frame_writes++;
            end
        end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
            check_eq("wr_missing", 64'(wr_en), 64'd1);
            void'(exp_wr.pop_front());
        end
        exp_busy = frame_active && (cyc >= busy_from) && (exp_done < 0 || cyc < exp_done);
        check_eq("busy", 64'(busy), 64'(exp_busy));
        if (done || cyc == exp_done) begin
            check_eq("done", 64'(done), 64'(cyc == exp_done));
            if (done) begin
                frame_done   = 1'b1;
                frame_active = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (hold_cnt > 0) begin
            stall = 1'b1;
            hold_cnt--;
        end else if (rand_stall) begin
            stall = ($urandom_range(0, 3) == 0);
        end else begin
            stall = 1'b0;
        end
        @(negedge clk);
        if (mon_en) monitor();
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int w, input int h);
        cfg_base   = base;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        start      = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                exp_rd.push_back('{AW'(longint'(base) + longint'(r) * exp_stride(w)
                                      + longint'(c) * 3), c == 0, r == 0 && c == 0});
            end
        end
        frame_reads  = 0;
        frame_writes = 0;
        frame_done   = 1'b0;
        if (w == 0 || h == 0) begin
            exp_done     = cyc + 1;
            frame_active = 1'b0;
        end else begin
            exp_done     = -1;
            frame_active = 1'b1;
            busy_from    = cyc + 1;
        end
        tick();
        start      = 1'b0;
        cfg_base   = AW'($urandom);
        cfg_width  = 16'($urandom);
        cfg_height = 16'($urandom);
    endtask

    task automatic finish_frame(input int npix, input int restart);
        int n = 0;
        while (!frame_done && n < npix * 6 + 40) begin
            if (restart > 0 && n == restart) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        check_eq("frame_done", 64'(frame_done), 64'd1);
        repeat (3) tick();
        check_eq("reads", 64'(frame_reads), 64'(npix));
        check_eq("writes", 64'(frame_writes), 64'(npix));
        check_eq("rd_left", 64'(exp_rd.size()), 64'd0);
        check_eq("wr_left", 64'(exp_wr.size()), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int w, input int h,
                             input int restart);
        start_frame(base, w, h);
        finish_frame(w * h, restart);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        pend_v       = 1'b0;
        exp_done     = -1;
        frame_active = 1'b0;
        tick();
        check_eq("rst_outs", 64'(|{rd_en, rd_addr, pix_en, pix_data, hsync, vsync, wr_en,
                                   wr_addr, wr_data, busy, done}), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        cfg_base   = '0;
        cfg_width  = '0;
        cfg_height = '0;
        mon_en     = 1'b0;
        rand_stall = 1'b0;
        stall_hold_arm = 1'b0;
        repeat (3) tick();
        check_eq("rst_init", 64'(|{rd_en, rd_addr, pix_en, pix_data, hsync, vsync, wr_en,
                                   wr_addr, wr_data, busy, done}), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        run_frame(24'h0, 4, 2, 0);
        run_frame(24'h0, 3, 2, 0);
        stall_hold_arm = 1'b1;
        run_frame(24'h0, 4, 2, 0);

        // Abort two cycles into a frame, then confirm a clean restart.
        start_frame(24'h100, 4, 2);
        tick();
        reset_dut();
        repeat (6) tick();
        run_frame(24'h100, 4, 2, 0);

        run_frame(24'h40, 4, 0, 0);
        run_frame(24'h40, 0, 3, 0);
        run_frame(24'h200, 6, 3, 4);
        run_frame(24'hFFFFF0, 297, 1, 0);

        rand_stall = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame(AW'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                      (f % 3 == 0) ? 3 : 0);
        end
        rand_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
